// File: rtl/udp_dram_writer_pkg.sv
// udp_dram_writer_pkg: shared constants, state encoding and burst sizing
// for the UDP receive-to-DRAM AXI4 write path.
package udp_dram_writer_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] CACHE_BUF  = 4'b0011;

    localparam int CTRL_LEN_MSB  = 39;
    localparam int CTRL_LEN_LSB  = 32;
    localparam int DATA_STRB_MSB = 35;
    localparam int DATA_STRB_LSB = 32;
    localparam int DATA_DATA_MSB = 31;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_CALC = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5
    } state_t;

    // Beats for the next burst: smallest of remaining beats, burst cap
    // and the beats left before the next 4 KiB page boundary.
    function automatic logic [8:0] burst_beats(
        input logic [8:0]  rem,
        input logic [8:0]  max_beats,
        input logic [12:0] page
    );
        logic [12:0] m;
        m = {4'b0, rem};
        if ({4'b0, max_beats} < m) m = {4'b0, max_beats};
        if (page < m) m = page;
        return m[8:0];
    endfunction

endpackage

// File: rtl/udp_dram_writer.sv
// udp_dram_writer: drains the UDP ctrl/data FIFOs and writes each block to
// DRAM as AXI4 INCR bursts, split at MAX_BURST beats and 4 KiB pages.
module udp_dram_writer
    import udp_dram_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [39:0]           ctrl_dout,
    input  logic                  ctrl_empty,
    output logic                  ctrl_re,
    input  logic [35:0]           data_dout,
    input  logic                  data_empty,
    output logic                  data_re,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_err
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [8:0]            rem;
    logic [8:0]            beats;
    logic [7:0]            wcnt;
    logic [12:0]           page;
    logic [8:0]            beats_c;
    logic                  w_hs;

    assign page    = (13'd4096 - {1'b0, addr[11:0]}) >> 2;
    assign beats_c = burst_beats(rem, 9'(MAX_BURST), page);

    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awcache = CACHE_BUF;
    assign m_axi_awprot  = 3'b000;

    // W channel runs straight off the FWFT head so a beat moves every clock.
    assign m_axi_wvalid = (state == S_W) && !data_empty;
    assign m_axi_wdata  = data_dout[DATA_DATA_MSB:0];
    assign m_axi_wstrb  = data_dout[DATA_STRB_MSB:DATA_STRB_LSB];
    assign m_axi_wlast  = (state == S_W) && (wcnt == 8'd0);
    assign w_hs         = m_axi_wvalid & m_axi_wready;
    assign data_re      = w_hs;
    assign busy         = (state != S_IDLE);

    // Block sequencer: command fetch, burst sizing, AW, W and B phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            addr          <= '0;
            rem           <= '0;
            beats         <= '0;
            wcnt          <= '0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
            ctrl_re       <= 1'b0;
            done          <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            ctrl_re <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!ctrl_empty) begin
                        ctrl_re <= 1'b1;
                        state   <= S_CMD;
                    end
                end
                S_CMD: begin
                    addr <= ADDR_WIDTH'(ctrl_dout[31:0] & 32'hFFFF_FFFC);
                    rem  <= {1'b0, ctrl_dout[CTRL_LEN_MSB:CTRL_LEN_LSB]};
                    if (ctrl_dout[CTRL_LEN_MSB:CTRL_LEN_LSB] == 8'd0)
                        state <= S_IDLE;
                    else
                        state <= S_CALC;
                end
                S_CALC: begin
                    beats         <= beats_c;
                    m_axi_awaddr  <= addr;
                    m_axi_awlen   <= 8'(beats_c - 9'd1);
                    wcnt          <= 8'(beats_c - 9'd1);
                    m_axi_awvalid <= 1'b1;
                    state         <= S_AW;
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        state         <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        wcnt <= wcnt - 8'd1;
                        if (wcnt == 8'd0) begin
                            m_axi_bready <= 1'b1;
                            state        <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != RESP_OKAY) wr_err <= 1'b1;
                        addr <= addr + ADDR_WIDTH'({beats, 2'b00});
                        rem  <= rem - beats;
                        if (rem == beats) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_dram_writer.sv
// tb_udp_dram_writer: FIFO + AXI slave models around udp_dram_writer with
// scoreboard queues for expected AW commands and W beats.
module tb_udp_dram_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] ctrl_dout;
    logic        ctrl_empty;
    logic        ctrl_re;
    logic [35:0] data_dout;
    logic        data_empty;
    logic        data_re;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready = 1'b1;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic        busy;
    logic        done;
    logic        wr_err;

    int errors = 0;
    int checks = 0;

    logic [39:0] cmem [0:63];
    logic [35:0] dmem [0:2047];
    int cwr = 0, crd = 0, dwr = 0, drd = 0;

    logic [39:0] exp_aw [$];
    logic [35:0] exp_w  [$];
    logic [1:0]  bq     [$];

    int done_cnt = 0, ctrl_cnt = 0, aw_cnt = 0, dre_cnt = 0, beats_seen = 0;
    logic rnd = 1'b0;
    logic pop_c = 0, pop_d = 0, b_set = 0, b_clr = 0;
    logic aw_done = 0, aw_wait = 0, prev_done = 0;
    logic [31:0] sv_addr;
    logic [7:0]  sv_len, cur_len;
    int beat = 0;

    assign ctrl_dout  = cmem[crd[5:0]];
    assign ctrl_empty = (cwr == crd);
    assign data_dout  = dmem[drd[10:0]];
    assign data_empty = (dwr == drd);

    always #5 clk = ~clk;

    udp_dram_writer #(.ADDR_WIDTH(32), .MAX_BURST(64)) dut (
        .clk(clk), .rst(rst),
        .ctrl_dout(ctrl_dout), .ctrl_empty(ctrl_empty), .ctrl_re(ctrl_re),
        .data_dout(data_dout), .data_empty(data_empty), .data_re(data_re),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .busy(busy), .done(done), .wr_err(wr_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_words(input int n);
        logic [3:0]  s;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            s = 4'($urandom_range(1, 15));
            d = $urandom;
            dmem[dwr[10:0]] = {s, d};
            dwr++;
            exp_w.push_back({s, d});
        end
    endtask

    task automatic push_ctrl(input logic [7:0] len, input logic [31:0] a);
        cmem[cwr[5:0]] = {len, a};
        cwr++;
    endtask

    task automatic expect_aw(input logic [31:0] a, input logic [7:0] len);
        exp_aw.push_back({len, a});
    endtask

    task automatic wait_done(input string tag, input int target, input int limit);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        chk(tag, done_cnt, target);
    endtask

    // FIFO/AXI slave model: apply last cycle's pops, then check this cycle.
    always @(negedge clk) begin
        logic [39:0] ea;
        logic [35:0] ew;
        if (pop_c) crd++;
        if (pop_d) drd++;
        if (b_clr) bvalid = 1'b0;
        if (b_set) begin
            bvalid = 1'b1;
            bresp  = (bq.size() > 0) ? bq.pop_front() : 2'b00;
        end
        pop_c = 0; pop_d = 0; b_set = 0; b_clr = 0;
        if (rnd) begin
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
        end else begin
            awready = 1'b1;
            wready  = 1'b1;
        end
        #1;
        if (rst) begin
            bvalid = 1'b0; aw_done = 0; aw_wait = 0; prev_done = 0;
        end else begin
            chk("data_re_hs", data_re, wvalid & wready);
            chk("wvalid_empty", wvalid & data_empty, 1'b0);
            if (aw_wait)
                chk("aw_stable", {awvalid, awaddr, awlen}, {1'b1, sv_addr, sv_len});
            if (awvalid && awready) begin
                aw_cnt++;
                chk("aw_attr", {awsize, awburst, awcache, awprot},
                    {3'b010, 2'b01, 4'b0011, 3'b000});
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", 1'b1, 1'b0);
                end else begin
                    ea = exp_aw.pop_front();
                    chk("aw_cmd", {awlen, awaddr}, ea);
                end
                cur_len = awlen;
                beat    = 0;
                aw_done = 1;
            end
            aw_wait = awvalid & ~awready;
            sv_addr = awaddr;
            sv_len  = awlen;
            if (wvalid && wready) begin
                beats_seen++;
                chk("w_after_aw", aw_done, 1'b1);
                if (exp_w.size() == 0) begin
                    chk("w_unexpected", 1'b1, 1'b0);
                end else begin
                    ew = exp_w.pop_front();
                    chk("w_beat", {wstrb, wdata}, ew);
                end
                chk("wlast", wlast, (beat == int'(cur_len)));
                beat++;
                if (wlast) begin
                    b_set   = 1;
                    aw_done = 0;
                end
            end
            if (bvalid && bready) b_clr = 1;
            if (done) begin
                done_cnt++;
                chk("done_pulse", prev_done, 1'b0);
            end
            prev_done = done;
            if (ctrl_re) begin
                ctrl_cnt++;
                pop_c = 1;
            end
            if (data_re) begin
                dre_cnt++;
                pop_d = 1;
            end
        end
    end

    initial begin
        int c0, a0, d0, r0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outs",
            {awvalid, wvalid, bready, ctrl_re, data_re, done, wr_err, busy}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // 1) single 8-beat burst
        @(negedge clk);
        d0 = dre_cnt;
        push_words(8);
        expect_aw(32'h0000_1000, 8'd7);
        push_ctrl(8'd8, 32'h0000_1000);
        wait_done("t1_done", 1, 200);
        chk("t1_pops", dre_cnt - d0, 8);
        chk("t1_aw_cnt", aw_cnt, 1);
        chk("t1_wr_err", wr_err, 1'b0);

        // 2) split at 4 KiB boundary
        push_words(4);
        expect_aw(32'h0000_0FF8, 8'd1);
        expect_aw(32'h0000_1000, 8'd1);
        push_ctrl(8'd4, 32'h0000_0FF8);
        wait_done("t2_done", 2, 200);
        chk("t2_aw_left", exp_aw.size(), 0);

        // 3) split at MAX_BURST
        push_words(200);
        expect_aw(32'h0000_0000, 8'd63);
        expect_aw(32'h0000_0100, 8'd63);
        expect_aw(32'h0000_0200, 8'd63);
        expect_aw(32'h0000_0300, 8'd7);
        a0 = aw_cnt;
        push_ctrl(8'd200, 32'h0000_0000);
        wait_done("t3_done", 3, 2000);
        chk("t3_aw_cnt", aw_cnt - a0, 4);

        // 4) FIFO underrun mid-burst with random backpressure
        rnd = 1'b1;
        d0 = dre_cnt;
        push_words(6);
        expect_aw(32'h0000_2FE0, 8'd7);
        expect_aw(32'h0000_3000, 8'd11);
        push_ctrl(8'd20, 32'h0000_2FE1);
        r0 = 0;
        while (drd != dwr && r0 < 500) begin
            @(negedge clk);
            r0++;
        end
        repeat (5) @(negedge clk);
        #2;
        chk("t4_stall_pops", dre_cnt - d0, 6);
        chk("t4_stall_busy", busy, 1'b1);
        push_words(14);
        wait_done("t4_done", 4, 2000);
        rnd = 1'b0;
        chk("t4_pops", dre_cnt - d0, 20);
        chk("t4_w_left", exp_w.size(), 0);

        // 5) SLVERR on first burst, block still completes
        bq.push_back(2'b10);
        bq.push_back(2'b00);
        push_words(4);
        expect_aw(32'h0000_0FF8, 8'd1);
        expect_aw(32'h0000_1000, 8'd1);
        push_ctrl(8'd4, 32'h0000_0FF8);
        wait_done("t5_done", 5, 200);
        chk("t5_wr_err", wr_err, 1'b1);
        chk("t5_aw_left", exp_aw.size(), 0);

        // 6a) zero-length entry dropped
        c0 = ctrl_cnt;
        a0 = aw_cnt;
        push_ctrl(8'd0, 32'h0000_8000);
        repeat (10) @(negedge clk);
        #2;
        chk("t6_ctrl_pop", ctrl_cnt - c0, 1);
        chk("t6_no_aw", aw_cnt - a0, 0);
        chk("t6_no_done", done_cnt, 5);
        chk("t6_err_sticky", wr_err, 1'b1);

        // 6b) reset in the middle of W
        r0 = beats_seen;
        push_words(16);
        expect_aw(32'h0000_4000, 8'd15);
        push_ctrl(8'd16, 32'h0000_4000);
        a0 = 0;
        while (beats_seen < r0 + 3 && a0 < 200) begin
            @(negedge clk);
            a0++;
        end
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("t6_rst_outs", {awvalid, wvalid, bready, busy, ctrl_re, data_re, done},
            7'h00);
        chk("t6_rst_err", wr_err, 1'b0);
        cwr = 0; crd = 0; dwr = 0; drd = 0;
        exp_aw.delete();
        exp_w.delete();
        bq.delete();
        @(negedge clk);
        rst = 1'b0;

        // 6c) normal block after reset
        push_words(8);
        expect_aw(32'h0000_5000, 8'd7);
        push_ctrl(8'd8, 32'h0000_5000);
        wait_done("t6_done", 6, 200);
        chk("t6_w_left", exp_w.size(), 0);
        chk("t6_aw_left", exp_aw.size(), 0);
        chk("t6_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
